// File: rtl/event_stream_monitor_if.sv
// Stream bundle between an event source and the event_stream_monitor.
// The master drives the events; the slave (the monitor) returns the evaluated streams and counters.
interface event_stream_monitor_if #(
  parameter int N_IN  = 2,
  parameter int W     = 32,
  parameter int DEPTH = 3
);
  logic                 en;
  logic [N_IN*W-1:0]    x;
  logic [N_IN-1:0]      new_x;
  logic [W-1:0]         a_out;
  logic                 a_valid;
  logic [DEPTH*W-1:0]   b_out;
  logic                 b_valid;
  logic [15:0]          evt_cnt;
  logic [15:0]          drop_cnt;

  modport master (
    output en, x, new_x,
    input  a_out, a_valid, b_out, b_valid, evt_cnt, drop_cnt
  );

  modport slave (
    input  en, x, new_x,
    output a_out, a_valid, b_out, b_valid, evt_cnt, drop_cnt
  );
endinterface

// File: rtl/event_stream_monitor.sv
// Two-stage event monitor: capture lanes on an event, then evaluate the lane sum
// (stream a) and the lane-0 history (stream b). Also counts accepted and dropped events.
module event_stream_monitor #(
  parameter int N_IN  = 2,
  parameter int W     = 32,
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  event_stream_monitor_if.slave bus
);

  logic                 s1_vld_q;
  logic [N_IN*W-1:0]    s1_x_q;
  logic [N_IN-1:0]      s1_new_q;
  logic [W-1:0]         a_q, a_d;
  logic                 a_vld_q;
  logic [DEPTH*W-1:0]   b_q, b_d;
  logic                 b_vld_q;
  logic [15:0]          evt_q, drop_q;
  logic                 evt;
  logic                 eval_a, eval_b;

  assign evt    = |bus.new_x;
  assign eval_a = s1_vld_q && (&s1_new_q);
  assign eval_b = s1_vld_q && s1_new_q[0];

  // Sum wraps naturally modulo 2^W; history shifts toward the oldest entry.
  always_comb begin
    a_d = '0;
    for (int i = 0; i < N_IN; i++) begin
      a_d = a_d + s1_x_q[i*W +: W];
    end
    b_d = b_q;
    b_d[W-1:0] = s1_x_q[W-1:0];
    for (int k = 1; k < DEPTH; k++) begin
      b_d[k*W +: W] = b_q[(k-1)*W +: W];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_vld_q <= 1'b0;
      s1_x_q   <= '0;
      s1_new_q <= '0;
      a_q      <= '0;
      a_vld_q  <= 1'b0;
      b_q      <= '0;
      b_vld_q  <= 1'b0;
      evt_q    <= '0;
      drop_q   <= '0;
    end else begin
      if (evt && bus.en && (evt_q != 16'hFFFF)) begin
        evt_q <= evt_q + 16'd1;
      end
      if (evt && !bus.en && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
      if (bus.en) begin
        s1_vld_q <= evt;
        if (evt) begin
          s1_x_q   <= bus.x;
          s1_new_q <= bus.new_x;
        end
        a_vld_q <= eval_a;
        if (eval_a) begin
          a_q <= a_d;
        end
        b_vld_q <= eval_b;
        if (eval_b) begin
          b_q <= b_d;
        end
      end else begin
        // Frozen: both stages keep their contents, only the pulses drop.
        a_vld_q <= 1'b0;
        b_vld_q <= 1'b0;
      end
    end
  end

  assign bus.a_out    = a_q;
  assign bus.a_valid  = a_vld_q;
  assign bus.b_out    = b_q;
  assign bus.b_valid  = b_vld_q;
  assign bus.evt_cnt  = evt_q;
  assign bus.drop_cnt = drop_q;

endmodule

// File: tb/tb_event_stream_monitor.sv
// Scoreboard bench for event_stream_monitor: stimulus pushes expected stream values,
// a negedge monitor pops and compares them and checks holds and counters.
module tb_event_stream_monitor;
  localparam int N_IN  = 2;
  localparam int W     = 32;
  localparam int DEPTH = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  event_stream_monitor_if #(.N_IN(N_IN), .W(W), .DEPTH(DEPTH)) bus ();
  event_stream_monitor_if #(.N_IN(4), .W(W), .DEPTH(DEPTH)) bus4 ();

  event_stream_monitor #(.N_IN(N_IN), .W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  event_stream_monitor #(.N_IN(4), .W(W), .DEPTH(DEPTH)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Reference model state
  logic [W-1:0]       qa[$];
  logic [DEPTH*W-1:0] qb[$];
  longint             hist[DEPTH];
  int                 m_evt  = 0;
  int                 m_drop = 0;
  logic [W-1:0]       mon_a = '0;
  logic [DEPTH*W-1:0] mon_b = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [N_IN*W-1:0] px(input longint l0, input longint l1);
    logic [W-1:0] a0, a1;
    a0 = l0[W-1:0];
    a1 = l1[W-1:0];
    return {a1, a0};
  endfunction

  function automatic logic [DEPTH*W-1:0] pack_hist();
    logic [DEPTH*W-1:0] r;
    logic [63:0]        v;
    r = '0;
    for (int k = 0; k < DEPTH; k++) begin
      v = hist[k];
      r[k*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  task automatic model_clear();
    qa.delete();
    qb.delete();
    for (int k = 0; k < DEPTH; k++) hist[k] = 0;
    m_evt  = 0;
    m_drop = 0;
  endtask

  // One clock of stimulus; expectations are queued in event order, counters update at the edge.
  task automatic cycle(input logic e, input logic [N_IN*W-1:0] xv, input logic [N_IN-1:0] nv);
    longint       acc;
    logic [63:0]  accv;
    bus.en    = e;
    bus.x     = xv;
    bus.new_x = nv;
    if (e && nv != 0) begin
      if (&nv) begin
        acc = 0;
        for (int i = 0; i < N_IN; i++) acc += longint'($signed(xv[i*W +: W]));
        accv = acc;
        qa.push_back(accv[W-1:0]);
      end
      if (nv[0]) begin
        for (int k = DEPTH-1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(xv[W-1:0]));
        qb.push_back(pack_hist());
      end
    end
    @(posedge clk);
    if (nv != 0) begin
      if (e) m_evt  = (m_evt  < 65535) ? m_evt + 1  : 65535;
      else   m_drop = (m_drop < 65535) ? m_drop + 1 : 65535;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_a = '0;
      mon_b = '0;
      chk("rst_a_out", bus.a_out, 0);
      chk("rst_b_out", bus.b_out, 0);
      chk("rst_valids", {bus.a_valid, bus.b_valid}, 0);
      chk("rst_counts", {bus.evt_cnt, bus.drop_cnt}, 0);
    end else begin
      if (bus.a_valid) begin
        if (qa.size() == 0) chk("a_unexpected_valid", bus.a_valid, 1'b0);
        else begin
          mon_a = qa.pop_front();
          chk("a_out", bus.a_out, mon_a);
        end
      end else chk("a_hold", bus.a_out, mon_a);
      if (bus.b_valid) begin
        if (qb.size() == 0) chk("b_unexpected_valid", bus.b_valid, 1'b0);
        else begin
          mon_b = qb.pop_front();
          chk("b_out", bus.b_out, mon_b);
        end
      end else chk("b_hold", bus.b_out, mon_b);
      chk("evt_cnt", bus.evt_cnt, m_evt[15:0]);
      chk("drop_cnt", bus.drop_cnt, m_drop[15:0]);
    end
  end

  logic [W-1:0] rx[N_IN];
  logic [N_IN*W-1:0] xr;

  initial begin
    bus.en = 1'b1; bus.x = '0; bus.new_x = '0;
    bus4.en = 1'b1; bus4.x = '0; bus4.new_x = '0;
    model_clear();
    @(posedge clk); #1;
    do_reset();

    // Basic event, latency and stream rules
    cycle(1, px(1, 2), 2'b11);
    @(negedge clk) chk("latency_early", bus.a_valid, 1'b0);
    cycle(1, '0, 2'b00);
    @(negedge clk) chk("latency_a_valid", bus.a_valid, 1'b1);
    chk("latency_b_valid", bus.b_valid, 1'b1);
    cycle(1, px(4, 0), 2'b01);
    cycle(1, px(0, 5), 2'b10);
    cycle(1, '0, 2'b00);
    cycle(1, px(10, 10), 2'b11);
    cycle(1, px(100, 100), 2'b11);
    cycle(1, '0, 2'b00);
    @(negedge clk) chk("b2b_second_a_valid", bus.a_valid, 1'b1);
    cycle(1, px(32'h7FFFFFFF, 1), 2'b11);
    cycle(1, '0, 2'b00);
    cycle(1, '0, 2'b00);
    chk("wrap_a_out", bus.a_out, 32'h80000000);

    // Freeze with a pending stage-1 event
    cycle(1, px(7, 8), 2'b11);
    for (int i = 0; i < 3; i++) begin
      cycle(0, px(i + 1, i + 2), 2'b11);
      @(negedge clk) chk("en0_no_pulse", {bus.a_valid, bus.b_valid}, 2'b00);
    end
    cycle(1, '0, 2'b00);
    @(negedge clk) chk("en_rise_emerges", bus.a_valid, 1'b1);
    chk("drop_after_freeze", bus.drop_cnt, 16'd3);
    repeat (3) cycle(1, '0, 2'b00);

    // Reset one cycle after capture discards the in-flight event
    cycle(1, px(9, 9), 2'b11);
    do_reset();
    repeat (4) cycle(1, '0, 2'b00);

    // Four-lane instance
    bus4.x = {32'd4, 32'd3, 32'd2, 32'd1};
    bus4.new_x = 4'hF;
    @(posedge clk); #1;
    bus4.new_x = 4'h0;
    @(negedge clk) chk("n4_early_valid", bus4.a_valid, 1'b0);
    @(negedge clk) chk("n4_a_valid", bus4.a_valid, 1'b1);
    chk("n4_a_out", bus4.a_out, 32'd10);
    chk("n4_b_entry0", bus4.b_out[W-1:0], 32'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N_IN; i++) begin
        case ($urandom_range(7))
          0: rx[i] = 32'h7FFFFFFF;
          1: rx[i] = 32'h80000000;
          2: rx[i] = 32'hFFFFFFFF;
          default: rx[i] = $urandom;
        endcase
      end
      xr = {rx[1], rx[0]};
      cycle(($urandom_range(4) != 0), xr, N_IN'($urandom_range(3)));
    end

    for (int t = 0; t < 20 && (qa.size() != 0 || qb.size() != 0); t++) cycle(1, '0, 2'b00);
    chk("drain_queues_empty", 32'(qa.size() + qb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
